// File: rtl/alu_sequencer.sv
// Program-driven command issuer for the 16-bit ALU breadboard: steps through a
// loaded program, captures each ALU result and offers it on a valid/ready port.
module alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [2*WIDTH+4:0] prog_data,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  output logic [WIDTH-1:0]   a_in,
  output logic [WIDTH-1:0]   b_in,
  output logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_error,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_error,
  output logic [AW-1:0]      res_index,
  output logic               busy,
  output logic               done
);

  localparam int PW = 2*WIDTH + 5;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW:0]      len_q, len_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] fwd_q, fwd_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rerr_q, rerr_d;
  logic [AW-1:0]    ridx_q, ridx_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  logic [PW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    ld_pc;
  logic [PW-1:0]    ent;
  logic             last;
  logic             load;

  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) mem_q[prog_addr] <= prog_data;
  end

  // Entry to be issued next: entry 0 when launching from IDLE, else the successor of pc.
  assign ld_pc = (state_q == S_IDLE) ? '0 : pc_q + AW'(1);
  assign ent   = mem_q[ld_pc];
  assign last  = ({1'b0, pc_q} == len_q - (AW+1)'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    fwd_d   = fwd_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    ridx_d  = ridx_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        a_d  = '0;
        b_d  = '0;
        op_d = '0;
        if (start && prog_len != '0) begin
          len_d   = prog_len;
          pc_d    = '0;
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        rdata_d = alu_result;
        rerr_d  = alu_error;
        ridx_d  = pc_q;
        fwd_d   = alu_result;
        vld_d   = 1'b1;
        op_d    = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          vld_d = 1'b0;
          if (last) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            load    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        a_d     = '0;
        b_d     = '0;
        op_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Forwarding substitutes the last captured result for the stored operand A.
    if (load) begin
      op_d = ent[PW-2 -: 4];
      b_d  = ent[WIDTH-1:0];
      a_d  = ent[PW-1] ? fwd_q : ent[2*WIDTH-1 -: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      fwd_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      ridx_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      fwd_q   <= fwd_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      ridx_q  <= ridx_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign a_in      = a_q;
  assign b_in      = b_q;
  assign opcode    = op_q;
  assign res_valid = vld_q;
  assign res_data  = rdata_q;
  assign res_error = rerr_q;
  assign res_index = ridx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, program-level reference model and a
// result scoreboard drained by an independent monitor.
module tb_alu_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = 16;
  localparam int PW    = 2*W + 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [PW-1:0] prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic [W-1:0]  a_in, b_in, res_data, alu_result;
  logic [3:0]    opcode;
  logic          alu_error, res_valid, res_error, busy, done;
  logic [AW-1:0] res_index;

  always #5 clk = ~clk;

  alu_sequencer #(.DEPTH(DEPTH), .AW(AW), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
    .a_in(a_in), .b_in(b_in), .opcode(opcode),
    .alu_result(alu_result), .alu_error(alu_error),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_error(res_error), .res_index(res_index), .busy(busy), .done(done)
  );

  // ALU behaviour, result is {error, value}
  function automatic logic [W:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W:0] prev);
    logic [W:0]     s;
    logic [2*W-1:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = a * b;
    case (op)
      4'd0:    return prev;
      4'd1:    return {a < b, a - b};
      4'd4:    return s;
      4'd5:    return {|m[2*W-1:W], m[W-1:0]};
      4'd6:    return {1'b0, a ^ b};
      4'd15:   return '0;
      default: return {1'b0, a};
    endcase
  endfunction

  logic [W:0] alu_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) alu_q <= '0;
    else        alu_q <= alu_fn(opcode, a_in, b_in, alu_q);
  end
  assign alu_result = alu_q[W-1:0];
  assign alu_error  = alu_q[W];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct packed { logic [W-1:0] d; logic e; logic [AW-1:0] i; } exp_t;
  exp_t          sb[$];
  logic [PW-1:0] prog_m [DEPTH];
  logic [W-1:0]  fwd_m = '0;
  logic [W:0]    prev_m = '0;
  int            exp_done = 0;

  task automatic predict(input int len);
    logic [PW-1:0] e;
    logic [W-1:0]  a;
    logic [W:0]    r;
    for (int k = 0; k < len; k++) begin
      e = prog_m[k];
      a = e[PW-1] ? fwd_m : e[2*W-1 -: W];
      r = alu_fn(e[PW-2 -: 4], a, e[W-1:0], prev_m);
      sb.push_back('{r[W-1:0], r[W], AW'(k)});
      fwd_m  = r[W-1:0];
      prev_m = r;
    end
  endtask

  // Monitor
  int   done_cnt = 0;
  int   rise_q[$];
  logic last_v = 1'b0, last_done = 1'b0, stall = 1'b0;
  logic [W-1:0]  sd;
  logic          se;
  logic [AW-1:0] si;

  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 1'b0; last_v = 1'b0; last_done = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("done_single_cycle", last_done, 0);
        end
        if (stall) begin
          chk("held_valid", res_valid, 1);
          chk("held_data", res_data, sd);
          chk("held_error", res_error, se);
          chk("held_index", res_index, si);
        end
        if (res_valid) begin
          chk("hold_opcode_noop", opcode, 0);
          if (!last_v) rise_q.push_back(cyc);
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_result: got index %0d data %0d, expected none", res_index, res_data);
          end else begin
            ex = sb.pop_front();
            chk("res_data", res_data, ex.d);
            chk("res_error", res_error, ex.e);
            chk("res_index", res_index, ex.i);
          end
        end
        stall = res_valid && !res_ready;
        sd = res_data; se = res_error; si = res_index;
        last_v = res_valid;
        last_done = done;
      end
    end
  end

  logic rnd_ready = 1'b0;
  initial forever begin
    @(posedge clk); #2;
    if (rnd_ready) res_ready = ($urandom_range(0, 3) != 0);
  end

  int t_start = 0;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int addr, input logic fwd, input logic [3:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic upd);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_data = {fwd, op, a, b};
    tick();
    prog_we = 1'b0;
    if (upd) prog_m[addr] = {fwd, op, a, b};
  endtask

  task automatic pulse_start(input int len);
    prog_len = (AW+1)'(len); start = 1'b1;
    tick();
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin tick(); k++; end
    chk("run_completes", busy, 0);
    tick(2);
    chk("scoreboard_drained", sb.size(), 0);
    chk("done_count", done_cnt, exp_done);
  endtask

  task automatic run(input int len);
    pulse_start(len);
    predict(len);
    if (len != 0) exp_done++;
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int len;
    logic [3:0] ops [6];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd4; ops[3] = 4'd5; ops[4] = 4'd6; ops[5] = 4'd15;

    #12;
    chk("rst_a_in", a_in, 0);     chk("rst_b_in", b_in, 0);
    chk("rst_opcode", opcode, 0); chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0); chk("rst_res_index", res_index, 0);
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    tick(); reset = 1'b1; tick();

    // Single add
    res_ready = 1'b1;
    write_entry(0, 0, 4'd4, 16'd355, 16'd5, 1);
    pulse_start(1);
    predict(1); exp_done++;
    chk("issue_opcode", opcode, 4); chk("issue_a", a_in, 355); chk("issue_b", b_in, 5);
    chk("issue_busy", busy, 1);
    tick();
    chk("wait_no_valid", res_valid, 0);
    chk("wait_opcode_held", opcode, 4);
    tick();
    chk("first_valid_latency", res_valid, 1);
    wait_idle();

    // Overflow then NO-OP capture of previous output
    write_entry(0, 0, 4'd4, 16'd50000, 16'd50000, 1);
    write_entry(1, 0, 4'd0, 16'd1, 16'd2, 1);
    run(2);

    // Forwarding, clear opcode, throughput
    write_entry(0, 0, 4'd5, 16'd25, 16'd25, 1);
    write_entry(1, 1, 4'd4, 16'd777, 16'd5, 1);
    write_entry(2, 0, 4'd15, 16'd9, 16'd9, 1);
    write_entry(3, 1, 4'd4, 16'd123, 16'd1, 1);
    rise_q.delete();
    pulse_start(4);
    predict(4); exp_done++;
    tick(3);
    chk("fwd_issue_a", a_in, 625);
    chk("fwd_issue_opcode", opcode, 4);
    wait_idle();
    chk("rise_count", rise_q.size(), 4);
    if (rise_q.size() >= 3) begin
      chk("first_rise_latency", rise_q[0] - t_start, 2);
      chk("throughput_1", rise_q[1] - rise_q[0], 3);
      chk("throughput_2", rise_q[2] - rise_q[1], 3);
    end

    // Consumer back-pressure
    res_ready = 1'b0;
    pulse_start(2);
    predict(2); exp_done++;
    for (int k = 0; k < 20 && !res_valid; k++) tick();
    chk("valid_seen", res_valid, 1);
    tick(3);
    res_ready = 1'b1;
    wait_idle();

    // Reset during WAIT of entry 2
    pulse_start(4);
    predict(4);
    tick(7);
    chk("pre_reset_no_valid", res_valid, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_a_in", a_in, 0);   chk("mid_rst_b_in", b_in, 0);
    chk("mid_rst_opcode", opcode, 0); chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0); chk("mid_rst_error", res_error, 0);
    chk("mid_rst_index", res_index, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("pending_dropped", sb.size(), 2);
    sb.delete(); fwd_m = '0; prev_m = '0;
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("no_done_after_reset", done_cnt, exp_done);
    run(4);

    // Zero-length start
    pulse_start(0);
    for (int k = 0; k < 6; k++) begin
      chk("len0_busy", busy, 0); chk("len0_valid", res_valid, 0); chk("len0_done", done, 0);
      tick();
    end

    // start and program writes while busy are ignored
    write_entry(0, 0, 4'd1, 16'd10, 16'd3, 1);
    write_entry(1, 1, 4'd6, 16'd0, 16'hFFFF, 1);
    write_entry(2, 0, 4'd5, 16'd300, 16'd300, 1);
    pulse_start(3);
    predict(3); exp_done++;
    tick();
    pulse_start(1);
    write_entry(0, 0, 4'd4, 16'd1, 16'd1, 0);
    write_entry(1, 0, 4'd4, 16'd2, 16'd2, 0);
    wait_idle();
    run(3);

    // Randomized programs with random consumer stalls
    rnd_ready = 1'b1;
    for (int it = 0; it < 12; it++) begin
      len = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
      for (int k = 0; k < len; k++)
        write_entry(k, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)],
                    W'($urandom), ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 300)), 1);
      run(len);
    end
    rnd_ready = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command initiator for the 16-bit ALU breadboard. It is the issuing end of the `a_in`/`b_in`/`opcode` interface that the breadboard consumes.
- Holds a small program of ALU operations, loaded through a write port. On `start` it issues the operations one at a time and captures each `final_output`/`error` pair.
- Each captured result is presented on a valid/ready result port. Results can optionally be forwarded as operand A of the next operation.

Parameters:
- DEPTH, 16, number of program entries.
- AW, 4, program address width (log2 DEPTH).
- WIDTH, 16, operand and result width.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_data  in  2*WIDTH+5  entry layout {fwd[1], opcode[4], a[WIDTH], b[WIDTH]}.
- prog_len  in  AW+1  number of entries to run, 0..DEPTH; sampled on start.
- start  in  1  one-cycle pulse that begins a run.
- a_in  out  WIDTH  operand A to the ALU.
- b_in  out  WIDTH  operand B to the ALU.
- opcode  out  4  ALU opcode.
- alu_result  in  WIDTH  ALU final_output.
- alu_error  in  1  ALU error.
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- res_error  out  1  captured error flag.
- res_index  out  AW  program index that produced the result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; pc=0; len register=0.
  - All outputs 0: a_in, b_in, opcode (NO-OP), res_valid, res_data, res_error, res_index, busy, done.
  - Forward register=0.
  - Program memory is not reset.
- All ALU-facing outputs are registered. The ALU registers its inputs on the same clk edge, so the result is valid one cycle after issue.
- Program writes:
  - Accepted only in IDLE. prog_we while busy is ignored.
  - A write is visible to a start in the following cycle.
- IDLE:
  - Outputs are opcode=0, a_in=0, b_in=0.
  - start=1 with prog_len!=0: latch len, pc=0, go to ISSUE.
  - start=1 with prog_len=0: stay in IDLE, no done pulse.
  - start while busy is ignored.
- ISSUE (1 cycle):
  - opcode=entry[pc].opcode, b_in=entry[pc].b.
  - a_in = fwd ? forward register : entry[pc].a.
  - Go to WAIT.
- WAIT (1 cycle):
  - Outputs are held.
  - At the closing edge: res_data=alu_result, res_error=alu_error, res_index=pc, forward register=alu_result, res_valid=1.
  - Go to HOLD.
- HOLD:
  - Drive opcode=0 (NO-OP). a_in and b_in keep their values.
  - res_valid stays high and data stays stable until res_ready=1.
  - On the handshake edge res_valid drops. If pc==len-1, go to DONE; otherwise pc+1 and go to ISSUE.
- DONE: done=1 for one cycle, then IDLE.
- Throughput: one result per 3 cycles when res_ready is held high.
- First result: res_valid rises 2 cycles after the start edge.
- Opcode 15 in a program:
  - Issued normally; the ALU clears itself and the captured result is 0.
  - The forward register becomes 0.
- Opcode 0 issues a NO-OP and captures the ALU's previous output.
- Error handling: alu_error is passed through only. The run continues.
- Reset mid-run: immediate return to IDLE with outputs 0. A pending result is dropped.
- len=DEPTH: pc runs 0..DEPTH-1 without wrap.

Test Plan:
- Load entry0 {0,4,355,5}, len=1, start -> opcode=4, a_in=355, b_in=5 in ISSUE; res_data=360, res_error=0, res_index=0; done pulses once after the handshake.
- Entry {0,4,50000,50000} -> res_data=34464, res_error=1; the sequencer continues to the next entry.
- Entries {0,5,25,25}, {1,4,x,5}, len=2 -> results 625 then 630; second issue drives a_in=625.
- res_ready low for 3 cycles after res_valid -> res_valid, res_data and res_index stable for those 3 cycles; opcode=0 while held; a result every 3 cycles once ready is high.
- Assert reset low during WAIT of entry 2 in a 4-entry run -> outputs 0 immediately, busy=0, no done; a new start reruns from pc=0 with the program intact.
- start with prog_len=0 -> busy stays 0, no res_valid, no done.
- start pulsed while busy, and prog_we while busy -> no effect on pc or the program.
